// File: rtl/sys_array_ctrl.sv
// sys_array_ctrl
//   Job sequencer for a weight-stationary ARRAY_SIZE x ARRAY_SIZE systolic grid.
//   On start it loads one weight matrix through the param_load chain. It then
//   streams num_rows input vectors into the left edge with per-column skew and
//   raises per-column capture strobes as results leave the bottom edge.
//   Only enables, addresses and param_load are driven; no data passes through.
//
//   Optional feature macro: SYS_ARRAY_CTRL_WEIGHT_REUSE_EN
//     defined   : reuse_weights=1 sampled with start skips the weight load
//     undefined : reuse_weights is ignored, every job loads weights
//
// Ports
//   clk, reset            clock (rising edge), async active-high reset
//   start, num_rows       job request and input vector count (sampled in IDLE)
//   reuse_weights         skip weight load (feature macro only)
//   busy, done            job in progress / one-cycle completion pulse
//   w_rd_en, w_rd_addr    weight buffer read (bottom row first)
//   param_load            weight shift/latch strobe to every cell
//   x_rd_en, x_rd_addr    per-column input read enable / packed row index
//   y_valid, y_wr_addr    per-column result capture strobe / packed row index
module sys_array_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 4,
  parameter int MAX_ROWS   = 16,
  parameter int ROW_W      = $clog2(MAX_ROWS + 1),
  parameter int W_AW       = $clog2(ARRAY_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ROW_W-1:0]            num_rows,
  input  logic                        reuse_weights,
  output logic                        busy,
  output logic                        done,
  output logic                        w_rd_en,
  output logic [W_AW-1:0]             w_rd_addr,
  output logic                        param_load,
  output logic [ARRAY_SIZE-1:0]       x_rd_en,
  output logic [ARRAY_SIZE*ROW_W-1:0] x_rd_addr,
  output logic [ARRAY_SIZE-1:0]       y_valid,
  output logic [ARRAY_SIZE*ROW_W-1:0] y_wr_addr
);

  // One counter serves both LOAD (0..N) and FEED (0..M+2N-2).
  localparam int CNT_W = $clog2(MAX_ROWS + 2*ARRAY_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FEED, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [ROW_W-1:0]            m_q, m_d;
  logic [ROW_W-1:0]            m_clamped;
  logic [CNT_W-1:0]            feed_last;

  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        w_rd_en_q, w_rd_en_d;
  logic [W_AW-1:0]             w_rd_addr_q, w_rd_addr_d;
  logic                        param_load_q, param_load_d;
  logic [ARRAY_SIZE-1:0]       x_rd_en_q, x_rd_en_d;
  logic [ARRAY_SIZE*ROW_W-1:0] x_rd_addr_q, x_rd_addr_d;
  logic [ARRAY_SIZE-1:0]       y_valid_q, y_valid_d;
  logic [ARRAY_SIZE*ROW_W-1:0] y_wr_addr_q, y_wr_addr_d;

  int                          tj, ty;

  // DATA_WIDTH only documents the array the controller drives.
  logic [DATA_WIDTH-1:0]       unused_dw;
  assign unused_dw = '0;
`ifndef SYS_ARRAY_CTRL_WEIGHT_REUSE_EN
  logic                        unused_reuse;
  assign unused_reuse = reuse_weights;
`endif

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    m_clamped = (num_rows > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : num_rows;
    feed_last = CNT_W'(m_q) + CNT_W'(2*ARRAY_SIZE - 2);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d   = m_clamped;
          cnt_d = '0;
`ifdef SYS_ARRAY_CTRL_WEIGHT_REUSE_EN
          if (reuse_weights)
            state_d = (m_clamped == '0) ? S_DONE : S_FEED;
          else
            state_d = S_LOAD;
`else
          state_d = S_LOAD;
`endif
        end
      end
      S_LOAD: begin
        if (cnt_q == CNT_W'(ARRAY_SIZE)) begin
          cnt_d   = '0;
          state_d = (m_q == '0) ? S_DONE : S_FEED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FEED: begin
        if (cnt_q == feed_last) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned
  // with the state they describe.
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    w_rd_en_d    = 1'b0;
    w_rd_addr_d  = '0;
    param_load_d = 1'b0;
    x_rd_en_d    = '0;
    x_rd_addr_d  = '0;
    y_valid_d    = '0;
    y_wr_addr_d  = '0;
    tj           = 0;
    ty           = 0;
    if (state_d == S_LOAD) begin
      // Bottom weight row is read first so it shifts deepest into the grid;
      // buffer latency of one cycle puts param_load one cycle behind the read.
      if (cnt_d < CNT_W'(ARRAY_SIZE)) begin
        w_rd_en_d   = 1'b1;
        w_rd_addr_d = W_AW'(ARRAY_SIZE - 1 - int'(cnt_d));
      end
      if (cnt_d >= CNT_W'(1)) param_load_d = 1'b1;
    end
    if (state_d == S_FEED) begin
      for (int j = 0; j < ARRAY_SIZE; j++) begin
        // Column j sees its inputs j cycles late and its results N cycles later.
        tj = int'(cnt_d) - j;
        ty = tj - ARRAY_SIZE;
        if (tj >= 0 && tj < int'(m_d)) begin
          x_rd_en_d[j]                  = 1'b1;
          x_rd_addr_d[j*ROW_W +: ROW_W] = ROW_W'(tj);
        end
        if (ty >= 0 && ty < int'(m_d)) begin
          y_valid_d[j]                  = 1'b1;
          y_wr_addr_d[j*ROW_W +: ROW_W] = ROW_W'(ty);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      m_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      w_rd_en_q    <= 1'b0;
      w_rd_addr_q  <= '0;
      param_load_q <= 1'b0;
      x_rd_en_q    <= '0;
      x_rd_addr_q  <= '0;
      y_valid_q    <= '0;
      y_wr_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      m_q          <= m_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      w_rd_en_q    <= w_rd_en_d;
      w_rd_addr_q  <= w_rd_addr_d;
      param_load_q <= param_load_d;
      x_rd_en_q    <= x_rd_en_d;
      x_rd_addr_q  <= x_rd_addr_d;
      y_valid_q    <= y_valid_d;
      y_wr_addr_q  <= y_wr_addr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign w_rd_en    = w_rd_en_q;
  assign w_rd_addr  = w_rd_addr_q;
  assign param_load = param_load_q;
  assign x_rd_en    = x_rd_en_q;
  assign x_rd_addr  = x_rd_addr_q;
  assign y_valid    = y_valid_q;
  assign y_wr_addr  = y_wr_addr_q;

endmodule
